hash_request_arbiter: RTL and testbench

- Shares one hash generator between NUM_REQ encryption/decryption blocks.
- Latches single-cycle byte-request pulses from each requester and selects one requester at a time, round-robin.
- Issues one request pulse to the hash generator only when the generator is GROUND or READY.
- Routes the returned hash byte and its pulse back to the granted requester only. Sits between the data-router-side cipher blocks and the hash generator.

---
 rtl/hash_request_arbiter.sv | 156 +++++++++++++++
 tb/tb_hash_request_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_request_arbiter.sv
// Round-robin arbiter sharing one hash generator between NUM_REQ cipher blocks.
// Latches request pulses, issues one generator request at a time and routes the reply back.
package hash_request_arbiter_pkg;
   typedef enum logic [2:0] {
      HG_GROUND = 3'd0,
      HG_INIT   = 3'd1,
      HG_BUSY   = 3'd2,
      HG_READY  = 3'd3,
      HG_ERROR  = 3'd4
   } hash_generator_state_t;
endpackage

module hash_request_arbiter
   import hash_request_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic [NUM_REQ-1:0]         req_pulse_in,
   input  logic [2:0]                 hash_generator_state,
   output logic                       request_byte_pulse_out,
   input  logic [7:0]                 hash_byte,
   input  logic                       hash_byte_pulse,
   output logic [7:0]                 hash_byte_out,
   output logic [NUM_REQ-1:0]         hash_byte_pulse_out,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       busy,
   output logic                       timeout_pulse
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_AWAIT = 2'd2
   } state_t;

   state_t             r_state,      w_state_next;
   logic [NUM_REQ-1:0] r_pending,    w_pending_next;
   logic [IDX_W-1:0]   r_last_grant, w_last_grant_next;
   logic [IDX_W-1:0]   r_grant_idx,  w_grant_idx_next;
   logic [CNT_W-1:0]   r_cnt,        w_cnt_next;
   logic [7:0]         r_hash_byte,  w_hash_byte_next;
   logic [NUM_REQ-1:0] r_deliver,    w_deliver_next;
   logic               r_req_pulse,  w_req_pulse_next;
   logic               r_busy,       w_busy_next;
   logic               r_timeout,    w_timeout_next;
   logic               w_gen_ready;

   // First pending requester after the previous grantee, wrapping modulo NUM_REQ.
   // Scanning from the farthest offset down lets the nearest hit overwrite the others.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                                input logic [IDX_W-1:0]   last);
      logic [IDX_W-1:0] pick;
      int               idx;
      pick = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (pend[IDX_W'(idx)]) pick = IDX_W'(idx);
      end
      return pick;
   endfunction

   assign w_gen_ready = (hash_generator_state == HG_GROUND) ||
                        (hash_generator_state == HG_READY);

   // NOTE: every signal gets its default before the case so no path can infer a latch.
   always_comb begin
      w_state_next      = r_state;
      w_pending_next    = r_pending;
      w_last_grant_next = r_last_grant;
      w_grant_idx_next  = r_grant_idx;
      w_cnt_next        = r_cnt;
      w_hash_byte_next  = r_hash_byte;
      w_deliver_next    = '0;
      w_req_pulse_next  = 1'b0;
      w_timeout_next    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (|r_pending) begin
               w_grant_idx_next = rr_pick(r_pending, r_last_grant);
               w_state_next     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_gen_ready) begin
               w_req_pulse_next            = 1'b1;
               w_pending_next[r_grant_idx] = 1'b0;
               w_cnt_next                  = '0;
               w_state_next                = ST_AWAIT;
            end
         end
         ST_AWAIT: begin
            if (hash_byte_pulse) begin
               w_hash_byte_next  = hash_byte;
               w_deliver_next    = NUM_REQ'(1) << r_grant_idx;
               w_last_grant_next = r_grant_idx;
               w_state_next      = ST_IDLE;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Abandoned request goes back into the pending set for a retry.
               w_timeout_next              = 1'b1;
               w_pending_next[r_grant_idx] = 1'b1;
               w_last_grant_next           = r_grant_idx;
               w_state_next                = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase

      // Applied last so a fresh request beats a same-cycle clear.
      w_pending_next = w_pending_next | req_pulse_in;
      w_busy_next    = (w_state_next != ST_IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state      <= ST_IDLE;
         r_pending    <= '0;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_grant_idx  <= '0;
         r_cnt        <= '0;
         r_hash_byte  <= '0;
         r_deliver    <= '0;
         r_req_pulse  <= 1'b0;
         r_busy       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_pending    <= w_pending_next;
         r_last_grant <= w_last_grant_next;
         r_grant_idx  <= w_grant_idx_next;
         r_cnt        <= w_cnt_next;
         r_hash_byte  <= w_hash_byte_next;
         r_deliver    <= w_deliver_next;
         r_req_pulse  <= w_req_pulse_next;
         r_busy       <= w_busy_next;
         r_timeout    <= w_timeout_next;
      end
   end

   assign request_byte_pulse_out = r_req_pulse;
   assign hash_byte_out          = r_hash_byte;
   assign hash_byte_pulse_out    = r_deliver;
   assign grant_idx              = r_grant_idx;
   assign busy                   = r_busy;
   assign timeout_pulse          = r_timeout;

endmodule

// File: tb/tb_hash_request_arbiter.sv
// Directed bench for hash_request_arbiter: latency, round-robin order, generator gating,
// timeout retry, stray replies, duplicate requests and reset mid-transaction.
module tb_hash_request_arbiter;
   import hash_request_arbiter_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int TO      = 4;

   logic       clk = 1'b0;
   logic       nrst;
   logic [1:0] req_pulse_in;
   logic [2:0] gen_state;
   logic       req_out;
   logic [7:0] hash_byte;
   logic       hash_pulse;
   logic [7:0] hash_out;
   logic [1:0] deliver;
   logic       grant;
   logic       busy;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   hash_request_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                    (clk),
      .nrst                   (nrst),
      .req_pulse_in           (req_pulse_in),
      .hash_generator_state   (gen_state),
      .request_byte_pulse_out (req_out),
      .hash_byte              (hash_byte),
      .hash_byte_pulse        (hash_pulse),
      .hash_byte_out          (hash_out),
      .hash_byte_pulse_out    (deliver),
      .grant_idx              (grant),
      .busy                   (busy),
      .timeout_pulse          (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; the cycle index moves by one.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in "cycle 0", reset released, all inputs idle.
   task automatic apply_reset();
      nrst         = 1'b0;
      req_pulse_in = '0;
      gen_state    = HG_READY;
      hash_byte    = '0;
      hash_pulse   = 1'b0;
      tick();
      tick();
      nrst = 1'b1;
   endtask

   initial begin
      int n;

      // Reset values
      apply_reset();
      check("rst_req",     req_out,  0);
      check("rst_deliver", deliver,  0);
      check("rst_hash",    hash_out, 0);
      check("rst_grant",   grant,    0);
      check("rst_busy",    busy,     0);
      check("rst_timeout", timeout,  0);

      // Single request, generator READY; reply in cycle 6 (delivery wins over timeout boundary)
      req_pulse_in = 2'b01;
      tick();                         // c1
      req_pulse_in = 2'b00;
      check("t1_c1_busy", busy, 0);
      tick();                         // c2
      check("t1_c2_busy", busy, 1);
      check("t1_c2_req",  req_out, 0);
      tick();                         // c3
      check("t1_c3_req",  req_out, 1);
      tick();                         // c4
      check("t1_c4_req",  req_out, 0);
      tick();                         // c5
      tick();                         // c6
      hash_byte  = 8'hA5;
      hash_pulse = 1'b1;
      tick();                         // c7
      hash_pulse = 1'b0;
      check("t1_deliver", deliver,  2'b01);
      check("t1_hash",    hash_out, 8'hA5);
      check("t1_grant",   grant,    0);
      check("t1_timeout", timeout,  0);
      tick();                         // c8
      check("t1_c8_deliver", deliver, 0);
      check("t1_c8_busy",    busy,    0);

      // Simultaneous requests: 0 then 1
      apply_reset();
      req_pulse_in = 2'b11;
      tick();                         // c1
      req_pulse_in = 2'b00;
      tick();                         // c2
      check("t2_grant0", grant, 0);
      tick();                         // c3
      check("t2_req0", req_out, 1);
      hash_byte  = 8'h11;
      hash_pulse = 1'b1;
      tick();                         // c4
      hash_pulse = 1'b0;
      check("t2_deliver0", deliver,  2'b01);
      check("t2_hash0",    hash_out, 8'h11);
      tick();                         // c5
      check("t2_grant1", grant, 1);
      tick();                         // c6
      check("t2_req1", req_out, 1);
      hash_byte  = 8'h22;
      hash_pulse = 1'b1;
      tick();                         // c7
      hash_pulse = 1'b0;
      check("t2_deliver1", deliver,  2'b10);
      check("t2_hash1",    hash_out, 8'h22);
      check("t2_grant1b",  grant,    1);

      // Generator busy: hold in ISSUE, then one request once GROUND
      apply_reset();
      gen_state    = HG_BUSY;
      req_pulse_in = 2'b10;
      tick();                         // c1
      req_pulse_in = 2'b00;
      tick();                         // c2
      n = 0;
      repeat (10) begin
         if (req_out) n++;
         tick();
      end                             // c12
      check("t3_hold_reqs", n,    0);
      check("t3_hold_busy", busy, 1);
      check("t3_grant",     grant, 1);
      gen_state = HG_GROUND;
      tick();                         // c13
      check("t3_req", req_out, 1);
      n = 0;
      repeat (3) begin
         tick();
         if (req_out) n++;
      end                             // c16: counter at TO-1
      check("t3_single_req", n, 0);
      hash_byte  = 8'h5A;
      hash_pulse = 1'b1;
      tick();                         // c17
      hash_pulse = 1'b0;
      check("t3_deliver", deliver, 2'b10);
      check("t3_no_to",   timeout, 0);

      // Timeout and retry
      apply_reset();
      req_pulse_in = 2'b01;
      tick();                         // c1
      req_pulse_in = 2'b00;
      tick();                         // c2
      tick();                         // c3
      check("t4_req", req_out, 1);
      tick();                         // c4
      tick();                         // c5
      tick();                         // c6
      check("t4_c6_timeout", timeout, 0);
      tick();                         // c7
      check("t4_timeout",  timeout, 1);
      check("t4_c7_busy",  busy,    0);
      check("t4_c7_deliv", deliver, 0);
      tick();                         // c8
      check("t4_retry_busy",  busy,    1);
      check("t4_retry_grant", grant,   0);
      check("t4_c8_timeout",  timeout, 0);
      tick();                         // c9
      check("t4_retry_req", req_out, 1);
      hash_byte  = 8'hC3;
      hash_pulse = 1'b1;
      tick();                         // c10
      hash_pulse = 1'b0;
      check("t4_deliver", deliver,  2'b01);
      check("t4_hash",    hash_out, 8'hC3);

      // Stray reply in IDLE, then duplicate request while pending
      apply_reset();
      hash_byte  = 8'hFF;
      hash_pulse = 1'b1;
      tick();                         // c1
      hash_pulse = 1'b0;
      check("t5_stray_deliver", deliver,  0);
      check("t5_stray_hash",    hash_out, 0);
      check("t5_stray_busy",    busy,     0);
      gen_state    = HG_BUSY;
      req_pulse_in = 2'b01;
      tick();                         // c2
      req_pulse_in = 2'b00;
      tick();                         // c3
      tick();                         // c4 (ISSUE, still pending)
      req_pulse_in = 2'b01;
      tick();                         // c5
      req_pulse_in = 2'b00;
      gen_state    = HG_READY;
      check("t5_no_early_req", req_out, 0);
      tick();                         // c6
      check("t5_req", req_out, 1);
      hash_byte  = 8'h3C;
      hash_pulse = 1'b1;
      tick();                         // c7
      hash_pulse = 1'b0;
      check("t5_deliver", deliver,  2'b01);
      check("t5_hash",    hash_out, 8'h3C);
      n = 0;
      repeat (8) begin
         tick();
         if (req_out) n++;
      end
      check("t5_extra_reqs", n,    0);
      check("t5_idle_busy",  busy, 0);

      // Reset during AWAIT, reply after release
      apply_reset();
      hash_byte    = 8'h99;
      req_pulse_in = 2'b01;
      tick();                         // c1
      req_pulse_in = 2'b00;
      tick();                         // c2
      tick();                         // c3
      check("t6_req", req_out, 1);
      nrst = 1'b0;
      #1;
      check("t6_rst_busy",  busy,    0);
      check("t6_rst_req",   req_out, 0);
      check("t6_rst_grant", grant,   0);
      tick();                         // c4
      nrst       = 1'b1;
      hash_byte  = 8'h77;
      hash_pulse = 1'b1;
      tick();                         // c5
      hash_pulse = 1'b0;
      n = 0;
      repeat (6) begin
         if (|{deliver, req_out, timeout, busy}) n++;
         tick();
      end
      check("t6_quiet",   n,        0);
      check("t6_hash",    hash_out, 0);
      check("t6_grant",   grant,    0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
